sccb_responder: RTL
===================

// Module: sccb_responder
// PURPOSE
//  OV7670-style SCCB target: the camera-side end of the SCCB link driven by our config master.
//  It holds a 256x8 register bank, accepts 3-phase writes, and answers 2-phase reads.
//  Use it as a synthesizable sensor stand-in for bring-up without a camera, and as the
//  bench responder for config-sequence regression. Inputs are oversampled on clk.
// PARAMETERS
//  DEV_ID       8'h42  write address; the read address is DEV_ID|1 (8'h43)
//  ACK_EN       1      1: pull SIO_D low in every 9th (X) bit of an accepted byte; 0: never drive the X bit
//  SYNC_STAGES  2      synchronizer depth on sio_c_i/sio_d_i (>=2)
// PORTS
//  clk          in   1  system clock; must be >= 8x the SIO_C frequency
//  rst_n        in   1  asynchronous, active-low reset
//  sio_c_i      in   1  SCCB clock from the master
//  sio_d_i      in   1  SCCB data line as seen on the pad
//  sio_d_oe     out  1  1 = pull SIO_D low (open drain); the pad ties its output to 0
//  wr_valid     out  1  1-cycle pulse when a register write commits
//  wr_addr      out  8  sub-address of the committed write
//  wr_data      out  8  data of the committed write
//  busy         out  1  high from START to STOP of a transaction addressed to DEV_ID
// BEHAVIOUR
//  Reset (rst_n=0, async): sio_d_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, FSM=IDLE,
//   sub-address pointer=0, bank loaded with defaults. Reset may hit mid-transaction; the
//   bank is restored and the in-flight byte is dropped.
//  Line conditioning: sync both lines, then register prior samples.
//   c_rise / c_fall = SIO_C edges. START = SIO_D falls while SIO_C=1. STOP = SIO_D rises while SIO_C=1.
//  Bit timing: master data sampled on c_rise, MSB first. Responder changes sio_d_oe only on
//   c_fall: the c_fall that ends bit 8 starts the drive, and the next c_fall releases it.
//  FSM states: IDLE, DEV, DEV_X, SUB, SUB_X, WDAT, WDAT_X, RDAT, RNA, IGNORE.
//  - START from any state -> DEV with bit count 0. This covers repeated START.
//  - STOP from any state -> IDLE, sio_d_oe=0, busy=0. No partial write commits.
//  - DEV: after 8 bits -> DEV_X. Byte==DEV_ID: set write mode. Byte==DEV_ID|1: set read mode.
//    Any other byte -> IGNORE, with no X drive and busy=0.
//  - DEV_X: write mode -> SUB. Read mode -> RDAT; load the shift register from
//    bank[pointer] on the c_fall that ends DEV_X.
//  - SUB: 8 bits latch the pointer -> SUB_X -> WDAT. A STOP here leaves a 2-phase write that
//    only sets the pointer for a later read.
//  - WDAT: 8 bits -> WDAT_X. In WDAT_X, commit bank[pointer]<=byte and pulse wr_valid with
//    wr_addr/wr_data. Then -> IGNORE: there is no auto-increment, and extra bytes get no
//    X drive and no commit.
//  - RDAT: drive sio_d_oe = ~bit, MSB first, on successive c_fall edges for 8 bits -> RNA
//    (oe=0). The master's NA bit is sampled and ignored. -> IGNORE until STOP.
//  Register rules:
//   bank defaults are all 8'h00, except 0x0A=8'h76 (PID), 0x0B=8'h73 (VER), 0x11=8'h80 (CLKRC).
//   0x0A and 0x0B are read-only. Writes to them still pulse wr_valid but do not change the bank.
//   A write to 0x12 (COM7) with bit7=1 is a soft reset. The cycle after the commit, all
//    registers return to defaults; COM7 then reads 8'h00 (bit7 self-clears).
//   A write and a same-cycle START or STOP cannot occur, because commits happen on c_rise
//    and START/STOP only happen while SIO_C=1.
//  Latency: wr_valid fires 1 clk after the c_rise that samples data bit 0 (the LSB).
// STRUCTURE
//  Package sccb_pkg: state enum; reg address constants (COM7=8'h12, CLKRC=8'h11, PID=8'h0A,
//   VER=8'h0B); default-value function def_val(addr); the 8'hFF end-of-table and
//   8'hF0 delay markers shared with the config master.
//  Sub-module sccb_line_sync: synchronizers plus c_rise/c_fall/start/stop detection.
//  The bank is a flop array; this is needed for the single-cycle soft reset.
// TESTING
//  1. Write 42/12/04 -> ACK in all three X bits; wr_valid once with addr 12, data 04; read of 12 returns 04.
//  2. Write 42/0A, STOP, then 43 and read -> SIO_D shifts 0111_0110 (76), NA ignored, busy drops at STOP.
//  3. Write 60/12/04 -> no ACK anywhere, wr_valid never pulses, bank unchanged, busy stays 0.
//  4. Write 42/40/D0, then 42/12/80 -> wr_valid x2; afterwards reg 40 reads 00 and reg 12 reads 00.
//  5. Write 42/3A, then STOP before the data byte -> no commit; a following read of 43 returns bank[3A]=00.
//  6. Write 42/0B/FF, then read 0B -> wr_valid pulses but the read returns 73.
//  7. Assert rst_n mid-RDAT -> sio_d_oe=0 at once, FSM in IDLE, defaults restored.

Source files
------------

// File: rtl/sccb_pkg.sv
// sccb_pkg
//   Shared definitions for the SCCB responder and the config master that talks
//   to it: responder FSM states, register address constants, the register
//   bank reset-value table and the markers used in config sequence tables.
package sccb_pkg;

  // Responder protocol states. The *_X states cover the 9th (don't-care /
  // acknowledge) bit that follows every byte.
  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV,
    S_DEV_X,
    S_SUB,
    S_SUB_X,
    S_WDAT,
    S_WDAT_X,
    S_RDAT,
    S_RNA,
    S_IGNORE
  } state_t;

  // Register addresses with special behaviour.
  localparam logic [7:0] REG_PID   = 8'h0A;
  localparam logic [7:0] REG_VER   = 8'h0B;
  localparam logic [7:0] REG_CLKRC = 8'h11;
  localparam logic [7:0] REG_COM7  = 8'h12;

  // Config-table markers understood by the config master.
  localparam logic [7:0] CFG_END   = 8'hFF;
  localparam logic [7:0] CFG_DELAY = 8'hF0;

  // Value a register takes after reset or after a COM7 soft reset.
  function automatic logic [7:0] def_val(input logic [7:0] addr);
    logic [7:0] val;
    val = 8'h00;
    if (addr == REG_PID)   val = 8'h76;
    if (addr == REG_VER)   val = 8'h73;
    if (addr == REG_CLKRC) val = 8'h80;
    return val;
  endfunction

  // Identification registers ignore writes.
  function automatic logic is_read_only(input logic [7:0] addr);
    return (addr == REG_PID) || (addr == REG_VER);
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// sccb_line_sync
//   Brings the asynchronous SCCB lines into the clk domain and derives the
//   bus events the responder FSM works from.
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   sio_c_i      raw SCCB clock line
//   sio_d_i      raw SCCB data line (as seen on the pad)
//   d_level      synchronized data line level
//   c_rise       1-cycle pulse on a rising SIO_C edge
//   c_fall       1-cycle pulse on a falling SIO_C edge
//   start        1-cycle pulse when SIO_D falls while SIO_C is high
//   stop         1-cycle pulse when SIO_D rises while SIO_C is high
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sio_c_i,
  input  logic sio_d_i,
  output logic d_level,
  output logic c_rise,
  output logic c_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] c_sync;
  logic [SYNC_STAGES-1:0] d_sync;
  logic                   c_prev;
  logic                   d_prev;
  logic                   c_now;
  logic                   d_now;

  // Reset to the idle bus level (both lines high) so that leaving reset
  // never looks like an edge, START or STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_sync <= '1;
      d_sync <= '1;
      c_prev <= 1'b1;
      d_prev <= 1'b1;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], sio_c_i};
      d_sync <= {d_sync[SYNC_STAGES-2:0], sio_d_i};
      c_prev <= c_sync[SYNC_STAGES-1];
      d_prev <= d_sync[SYNC_STAGES-1];
    end
  end

  assign c_now   = c_sync[SYNC_STAGES-1];
  assign d_now   = d_sync[SYNC_STAGES-1];
  assign d_level = d_now;
  assign c_rise  = c_now & ~c_prev;
  assign c_fall  = ~c_now & c_prev;

  // SIO_C must be high in both samples so a data change that races a clock
  // edge is never mistaken for START or STOP.
  assign start   = c_now & c_prev & d_prev & ~d_now;
  assign stop    = c_now & c_prev & ~d_prev & d_now;

endmodule

// File: rtl/sccb_responder.sv
// sccb_responder
//   Camera-side SCCB target with a 256x8 register bank. Accepts 3-phase
//   writes (ID, sub-address, data) and answers 2-phase reads (ID, data) from
//   the sub-address pointer left by the last write phase.
// Ports
//   clk       system clock, at least 8x the SIO_C frequency
//   rst_n     asynchronous active-low reset
//   sio_c_i   SCCB clock from the master
//   sio_d_i   SCCB data line as seen on the pad
//   sio_d_oe  1 = pull SIO_D low (open drain)
//   wr_valid  1-cycle pulse when a register write commits
//   wr_addr   sub-address of the committed write
//   wr_data   data of the committed write
//   busy      high while a transaction addressed to this device is open
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter bit         ACK_EN      = 1'b1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sio_c_i,
  input  logic       sio_d_i,
  output logic       sio_d_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  logic       d_level;
  logic       c_rise;
  logic       c_fall;
  logic       start;
  logic       stop;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [7:0] ptr;
  logic       rd_mode;
  logic [7:0] next_byte;
  logic [7:0] bank_rd;
  logic [7:0] bank [256];

  sccb_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .sio_c_i (sio_c_i),
    .sio_d_i (sio_d_i),
    .d_level (d_level),
    .c_rise  (c_rise),
    .c_fall  (c_fall),
    .start   (start),
    .stop    (stop)
  );

  assign next_byte = {shift_reg[6:0], d_level};
  assign bank_rd   = bank[ptr];

  // Protocol FSM. Master bits are taken on c_rise; sio_d_oe only moves on
  // c_fall so the line is stable for the whole SIO_C high phase. In the X
  // states bit_cnt is reused as a phase flag: 0 = the fall that starts the
  // acknowledge drive, 1 = the fall that releases it and leaves the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= 4'd0;
      shift_reg <= 8'h00;
      ptr       <= 8'h00;
      rd_mode   <= 1'b0;
      sio_d_oe  <= 1'b0;
      busy      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      if (stop) begin
        state    <= S_IDLE;
        bit_cnt  <= 4'd0;
        sio_d_oe <= 1'b0;
        busy     <= 1'b0;
      end else if (start) begin
        // Also handles a repeated START in the middle of a transaction.
        state    <= S_DEV;
        bit_cnt  <= 4'd0;
        sio_d_oe <= 1'b0;
      end else begin
        case (state)
          S_DEV, S_SUB, S_WDAT: begin
            if (c_rise) begin
              shift_reg <= next_byte;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (state == S_DEV) begin
                  if (next_byte == DEV_ID) begin
                    rd_mode <= 1'b0;
                    busy    <= 1'b1;
                    state   <= S_DEV_X;
                  end else if (next_byte == (DEV_ID | 8'h01)) begin
                    rd_mode <= 1'b1;
                    busy    <= 1'b1;
                    state   <= S_DEV_X;
                  end else begin
                    busy    <= 1'b0;
                    state   <= S_IGNORE;
                  end
                end else if (state == S_SUB) begin
                  ptr   <= next_byte;
                  state <= S_SUB_X;
                end else begin
                  // Commit on the rise that samples the data LSB.
                  wr_valid <= 1'b1;
                  wr_addr  <= ptr;
                  wr_data  <= next_byte;
                  state    <= S_WDAT_X;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          S_DEV_X, S_SUB_X, S_WDAT_X: begin
            if (c_fall) begin
              if (bit_cnt == 4'd0) begin
                sio_d_oe <= ACK_EN;
                bit_cnt  <= 4'd1;
              end else if (state == S_DEV_X && rd_mode) begin
                // The fall that ends the acknowledge already presents the
                // read data MSB; the rest follow on later falls.
                sio_d_oe  <= ~bank_rd[7];
                shift_reg <= {bank_rd[6:0], 1'b0};
                bit_cnt   <= 4'd1;
                state     <= S_RDAT;
              end else begin
                sio_d_oe <= 1'b0;
                bit_cnt  <= 4'd0;
                if (state == S_DEV_X)      state <= S_SUB;
                else if (state == S_SUB_X) state <= S_WDAT;
                else                       state <= S_IGNORE;
              end
            end
          end

          S_RDAT: begin
            // bit_cnt counts data bits already presented on the line.
            if (c_fall) begin
              if (bit_cnt == 4'd8) begin
                sio_d_oe <= 1'b0;
                bit_cnt  <= 4'd0;
                state    <= S_RNA;
              end else begin
                sio_d_oe  <= ~shift_reg[7];
                shift_reg <= {shift_reg[6:0], 1'b0};
                bit_cnt   <= bit_cnt + 4'd1;
              end
            end
          end

          S_RNA: begin
            // The master's NA bit is sampled here and deliberately ignored.
            if (c_rise) state <= S_IGNORE;
          end

          S_IDLE, S_IGNORE: begin
            sio_d_oe <= 1'b0;
          end

          default: begin
            state    <= S_IDLE;
            sio_d_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  // Register bank. Writes land the cycle wr_valid is high. A COM7 write with
  // bit7 set reloads every register instead, so COM7 itself reads back as
  // its default and the soft-reset bit clears on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) bank[i] <= def_val(i[7:0]);
    end else if (wr_valid && (wr_addr == REG_COM7) && wr_data[7]) begin
      for (int i = 0; i < 256; i++) bank[i] <= def_val(i[7:0]);
    end else if (wr_valid && !is_read_only(wr_addr)) begin
      bank[wr_addr] <= wr_data;
    end
  end

endmodule
